// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, addressing modes, instruction field
// positions and the fetch state encoding.
package sisc_pkg;

  localparam logic [3:0] OP_NOOP   = 4'd0;
  localparam logic [3:0] OP_LOD    = 4'd1;
  localparam logic [3:0] OP_STR    = 4'd2;
  localparam logic [3:0] OP_SWP    = 4'd3;
  localparam logic [3:0] OP_BRA    = 4'd4;
  localparam logic [3:0] OP_BRR    = 4'd5;
  localparam logic [3:0] OP_BNE    = 4'd6;
  localparam logic [3:0] OP_BNR    = 4'd7;
  localparam logic [3:0] OP_ALU_OP = 4'd8;
  localparam logic [3:0] OP_HLT    = 4'd15;

  localparam logic [3:0] AM_IMM = 4'd8;

  // imm overlaps rt: both start at bit 15
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int MM_MSB     = 27;
  localparam int MM_LSB     = 24;
  localparam int RD_MSB     = 23;
  localparam int RD_LSB     = 20;
  localparam int RS_MSB     = 19;
  localparam int RS_LSB     = 16;
  localparam int RT_MSB     = 15;
  localparam int RT_LSB     = 12;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sisc_pc_next.sv
// Next-PC selection: hold, clear, increment, absolute or PC-relative branch.
module sisc_pc_next #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  input  logic            pc_rst,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  output logic [PC_W-1:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc;
    if (pc_rst) begin
      pc_nxt = '0;
    end else if (pc_write) begin
      if (!pc_sel) begin
        pc_nxt = pc + PC_W'(1);
      end else if (br_sel) begin
        pc_nxt = PC_W'(imm);
      end else begin
        // relative target: imm is a signed displacement, result wraps
        pc_nxt = pc + PC_W'($signed(imm));
      end
    end
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC datapath fetch side: PC, instruction-memory read handshake with
// timeout, instruction register with field decode, and status register.
//
// state      | meaning
// FETCH_IDLE | no read outstanding; ir_load starts a fetch at the current pc
// FETCH_WAIT | read issued at imem_addr, waiting for imem_rdy or timeout
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int PC_W         = 16,
  parameter int INSTR_W      = 32,
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  input  logic [3:0]         stat_in,
  input  logic               stat_en,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rdy,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [15:0]        imm,
  output logic [3:0]         stat,
  output logic               ir_valid,
  output logic               fetch_busy,
  output logic               fetch_err
);

  localparam int TMO_W = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IMEM_TIMEOUT - 1);

  fetch_state_t        state_q;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     pc_nxt;
  logic [PC_W-1:0]     addr_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [3:0]          stat_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic                req_q;
  logic                busy_q;
  logic                valid_q;
  logic                err_q;

  sisc_pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc       (pc_q),
    .imm      (imm),
    .pc_rst   (pc_rst),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .pc_nxt   (pc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_IDLE;
      pc_q      <= '0;
      addr_q    <= '0;
      ir_q      <= '0;
      stat_q    <= '0;
      tmo_cnt_q <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pc_q    <= pc_nxt;
      valid_q <= 1'b0;
      if (stat_en) begin
        stat_q <= stat_in;
      end
      case (state_q)
        FETCH_IDLE: begin
          if (ir_load) begin
            // pc_q is the pre-update value, so fetch+increment reads the old PC
            addr_q    <= pc_q;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (ir_load) begin
            err_q <= 1'b1;
          end
          if (imem_rdy) begin
            ir_q    <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= FETCH_IDLE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= FETCH_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
      endcase
    end
  end

  assign pc         = pc_q;
  assign imem_addr  = addr_q;
  assign imem_req   = req_q;
  assign ir         = ir_q;
  assign stat       = stat_q;
  assign ir_valid   = valid_q;
  assign fetch_busy = busy_q;
  assign fetch_err  = err_q;

  assign opcode = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign mm     = ir_q[MM_MSB:MM_LSB];
  assign rd     = ir_q[RD_MSB:RD_LSB];
  assign rs     = ir_q[RS_MSB:RS_LSB];
  assign rt     = ir_q[RT_MSB:RT_LSB];
  assign imm    = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit; fetched words go through a
// scoreboard queue that is drained on every ir_valid pulse.
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_rst = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_sel = 1'b0;
  logic        br_sel = 1'b0;
  logic        ir_load = 1'b0;
  logic [3:0]  stat_in = 4'd0;
  logic        stat_en = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [3:0]  opcode, mm, rd, rs, rt, stat;
  logic [15:0] imm;
  logic        ir_valid, fetch_busy, fetch_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sisc_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_rst     (pc_rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .ir_load    (ir_load),
    .stat_in    (stat_in),
    .stat_en    (stat_en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdy   (imem_rdy),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .rd         (rd),
    .rs         (rs),
    .rt         (rt),
    .imm        (imm),
    .stat       (stat),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pc_step(input logic sel, input logic bsel);
    pc_write = 1'b1; pc_sel = sel; br_sel = bsel;
    tick();
    pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
  endtask

  task automatic do_fetch(input logic [15:0] exp_addr, input logic [31:0] word, input int delay);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    check_val("fetch_req_up", imem_req, 1);
    check_val("fetch_addr", imem_addr, exp_addr);
    repeat (delay) begin
      tick();
      check_val("fetch_addr_hold", imem_addr, exp_addr);
    end
    imem_rdy = 1'b1; imem_rdata = word; exp_q.push_back(word);
    tick();
    imem_rdy = 1'b0;
    check_val("fetch_req_down", imem_req, 0);
  endtask

  // scoreboard: every ir_valid pulse must match the oldest delivered word
  always @(negedge clk) begin
    if (ir_valid) begin
      if (exp_q.size() == 0) check_val("ir_valid_unexpected", ir_valid, 0);
      else check_val("sb_ir", ir, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(); tick();
    check_val("rst_pc", pc, 0);
    check_val("rst_ir", ir, 0);
    check_val("rst_stat", stat, 0);
    check_val("rst_req", imem_req, 0);
    check_val("rst_busy", fetch_busy, 0);
    check_val("rst_err", fetch_err, 0);
    check_val("rst_valid", ir_valid, 0);
    check_val("rst_addr", imem_addr, 0);
    rst = 1'b0;

    // minimum-latency fetch
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    check_val("t1_req", imem_req, 1);
    check_val("t1_addr", imem_addr, 0);
    check_val("t1_busy", fetch_busy, 1);
    imem_rdy = 1'b1; imem_rdata = 32'h8801_2000; exp_q.push_back(32'h8801_2000);
    tick();
    imem_rdy = 1'b0;
    check_val("t1_busy_drop", fetch_busy, 0);
    check_val("t1_req_drop", imem_req, 0);
    check_val("t1_ir", ir, 32'h8801_2000);
    check_val("t1_opcode", opcode, 8);
    check_val("t1_mm", mm, 8);
    check_val("t1_imm", imm, 16'h2000);
    check_val("t1_rd", rd, 0);
    check_val("t1_rs", rs, 1);
    check_val("t1_valid", ir_valid, 1);
    tick();
    check_val("t1_valid_pulse", ir_valid, 0);

    // load imm=0x0040 for the mid-fetch branch, then walk pc to 5
    do_fetch(16'h0000, 32'h4000_0040, 1);
    repeat (5) pc_step(1'b0, 1'b0);
    check_val("t2_pc5", pc, 16'h0005);
    ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    tick();
    ir_load = 1'b0; pc_write = 1'b0;
    check_val("t2_addr_old_pc", imem_addr, 16'h0005);
    check_val("t2_pc_inc", pc, 16'h0006);
    check_val("t2_req", imem_req, 1);
    pc_step(1'b1, 1'b1);
    check_val("t2_pc_abs", pc, 16'h0040);
    check_val("t2_addr_w1", imem_addr, 16'h0005);
    tick();
    check_val("t2_addr_w2", imem_addr, 16'h0005);
    tick();
    check_val("t2_addr_w3", imem_addr, 16'h0005);
    imem_rdy = 1'b1; imem_rdata = 32'h5000_FFFE; exp_q.push_back(32'h5000_FFFE);
    tick();
    imem_rdy = 1'b0;
    check_val("t2_req_drop", imem_req, 0);

    // branches
    pc_rst = 1'b1; tick(); pc_rst = 1'b0;
    check_val("br_pc_clear", pc, 0);
    repeat (16) pc_step(1'b0, 1'b0);
    check_val("br_pc10", pc, 16'h0010);
    pc_step(1'b1, 1'b0);
    check_val("br_rel_neg", pc, 16'h000E);
    do_fetch(16'h000E, 32'h4000_0100, 0);
    pc_step(1'b1, 1'b1);
    check_val("br_abs", pc, 16'h0100);
    do_fetch(16'h0100, 32'h4000_FFFF, 0);
    pc_step(1'b1, 1'b1);
    check_val("br_abs_ffff", pc, 16'hFFFF);
    pc_step(1'b0, 1'b0);
    check_val("br_inc_wrap", pc, 16'h0000);
    pc_step(1'b1, 1'b0);
    check_val("br_rel_wrap", pc, 16'hFFFF);

    // imem never answers
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    check_val("to_err_before", fetch_err, 0);
    n = 0;
    for (int i = 0; i < 40 && imem_req; i++) begin
      n++;
      tick();
    end
    check_val("to_wait_cycles", n, 15);
    check_val("to_err", fetch_err, 1);
    check_val("to_req", imem_req, 0);
    check_val("to_busy", fetch_busy, 0);
    check_val("to_ir_kept", ir, 32'h4000_FFFF);
    do_fetch(16'hFFFF, 32'h2123_4567, 2);
    check_val("to_err_sticky", fetch_err, 1);

    // status register during WAIT
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    stat_en = 1'b1; stat_in = 4'b0101;
    tick();
    stat_en = 1'b0; stat_in = 4'b1111;
    check_val("stat_load", stat, 4'b0101);
    check_val("stat_busy", fetch_busy, 1);
    tick();
    check_val("stat_hold", stat, 4'b0101);
    imem_rdy = 1'b1; imem_rdata = 32'hF000_0000; exp_q.push_back(32'hF000_0000);
    tick();
    imem_rdy = 1'b0;
    check_val("stat_hlt_opcode", opcode, 4'hF);

    // pc_rst wins over pc_write
    pc_rst = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    tick();
    pc_rst = 1'b0; pc_write = 1'b0;
    check_val("pcrst_prio", pc, 0);

    // rst in the middle of a fetch, then a late imem_rdy
    repeat (3) pc_step(1'b0, 1'b0);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    check_val("mr_req", imem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mr_req_drop", imem_req, 0);
    check_val("mr_busy", fetch_busy, 0);
    check_val("mr_pc", pc, 0);
    check_val("mr_ir", ir, 0);
    check_val("mr_stat", stat, 0);
    check_val("mr_err_clear", fetch_err, 0);
    imem_rdy = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rdy = 1'b0;
    check_val("mr_late_ir", ir, 0);
    check_val("mr_late_valid", ir_valid, 0);
    check_val("mr_late_req", imem_req, 0);
    tick();
    check_val("mr_late_ir2", ir, 0);

    // ir_load while WAIT is an error but the fetch still completes
    ir_load = 1'b1;
    tick();
    check_val("wl_err_before", fetch_err, 0);
    tick();
    ir_load = 1'b0;
    check_val("wl_err", fetch_err, 1);
    check_val("wl_req", imem_req, 1);
    check_val("wl_addr", imem_addr, 0);
    imem_rdy = 1'b1; imem_rdata = 32'h3012_0003; exp_q.push_back(32'h3012_0003);
    tick();
    imem_rdy = 1'b0;
    check_val("wl_req_drop", imem_req, 0);
    tick();
    check_val("wl_err_sticky", fetch_err, 1);
    check_val("wl_idle", imem_req, 0);

    tick(); tick();
    check_val("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
- Datapath-side responder to the SISC control FSM.
- Consumes ctrl's pc_rst, pc_write, pc_sel, br_sel and ir_load. Holds the PC, runs the instruction-memory read handshake and latches the IR.
- Decodes the fields that ctrl consumes (opcode, mm) and holds the status register that feeds ctrl's stat input.
- Adds a busy indication so the FSM can stall on a multi-cycle instruction memory.

Parameters:
- PC_W, 16, program counter and instruction address width.
- INSTR_W, 32, instruction width.
- IMEM_TIMEOUT, 15, maximum cycles to wait for imem_rdy before the fetch is aborted.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_rst  in  1  from ctrl: synchronous PC clear.
- pc_write  in  1  from ctrl: update PC this cycle.
- pc_sel  in  1  from ctrl: 0 = PC+1, 1 = branch target.
- br_sel  in  1  from ctrl: 1 = absolute target (imm), 0 = relative target (PC + sext(imm)).
- ir_load  in  1  from ctrl: start an instruction fetch at the current PC.
- stat_in  in  4  ALU condition codes {C,N,V,Z}.
- stat_en  in  1  load stat_in into the status register.
- imem_req  out  1  instruction read request.
- imem_addr  out  PC_W  read address, stable while imem_req is high.
- imem_rdy  in  1  read data valid; one-cycle pulse.
- imem_rdata  in  INSTR_W  instruction word.
- pc  out  PC_W  current PC.
- ir  out  INSTR_W  instruction register.
- opcode  out  4  ir[31:28].
- mm  out  4  ir[27:24].
- rd, rs, rt  out  4 each  ir[23:20], ir[19:16], ir[15:12].
- imm  out  16  ir[15:0].
- stat  out  4  status register.
- ir_valid  out  1  one-cycle pulse when ir has been updated.
- fetch_busy  out  1  high while a fetch is outstanding.
- fetch_err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (rst=1): pc=0, ir=0 (decodes as NOOP), stat=0, state=IDLE. imem_req, ir_valid, fetch_busy, fetch_err, timeout counter and addr register all 0. rst overrides every other input.
- PC update, evaluated after rst, in priority order:
  - pc_rst=1 -> pc=0.
  - Otherwise pc_write=1 with pc_sel=0 -> pc+1, wrapping 16'hFFFF to 0.
  - pc_write=1, pc_sel=1, br_sel=1 -> imm.
  - pc_write=1, pc_sel=1, br_sel=0 -> pc + sign-extended imm, modulo 2^16.
  - pc_write=0 -> hold.
- imm used for branch targets is the current IR field, not imem_rdata.
- FSM states: IDLE and WAIT.
  - IDLE, ir_load=1: capture addr = pc as it is before any same-cycle pc_write, so fetch plus increment in one cycle reads the old PC. Set imem_req=1, fetch_busy=1, clear the timeout counter, go to WAIT.
  - WAIT, imem_rdy=1: ir <= imem_rdata; ir_valid=1 for the next cycle; imem_req=0, fetch_busy=0; go to IDLE.
  - WAIT, imem_rdy=0: increment the timeout counter.
  - WAIT, counter reaches IMEM_TIMEOUT: set fetch_err=1, drop imem_req, leave ir unchanged, go to IDLE.
  - WAIT, ir_load=1: ignored, and fetch_err=1.
- Minimum latency: ir_load to ir updated is 2 cycles when imem_rdy returns the cycle after the request.
- imem_rdy in IDLE is ignored.
- imem_addr is held constant for the whole of WAIT, even if pc changes during the fetch.
- Status register: stat_en=1 -> stat <= stat_in on the next edge; otherwise hold. stat updates normally even while a fetch is in WAIT.
- Decode outputs are purely combinational from ir.
- rst asserted mid-fetch: return to IDLE immediately; imem_req=0 the next cycle; any late imem_rdy is ignored.

Decomposition:
- Shared package sisc_pkg holds:
  - Opcode constants: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15.
  - am_imm=8.
  - Instruction field bit positions.
  - Fetch state encoding.
- One sub-module, sisc_pc_next: combinational next-PC mux and adder (increment, absolute, relative).

Test Plan:
- Reset then ir_load with pc=0 and imem_rdy after 1 cycle, rdata=32'h8801_2000 -> imem_addr=0; ir=32'h88012000, opcode=8, mm=8, imm=16'h2000; ir_valid pulses once; fetch_busy high for exactly 1 cycle.
- Simultaneous ir_load and pc_write (pc_sel=0) at pc=5 -> imem_addr=5, pc=6; addr stays 5 across 3 wait cycles while pc_write=1 (br_sel=1, imm=16'h0040) sets pc to 16'h0040.
- Branches at pc=16'h0010:
  - ir imm=16'hFFFE, pc_sel=1, br_sel=0 -> pc=16'h000E.
  - br_sel=1, imm=16'h0100 -> pc=16'h0100.
  - pc=16'hFFFF with increment -> pc=0.
- imem_rdy never returns -> after 15 wait cycles fetch_err=1, imem_req=0, ir unchanged. A second ir_load then completes normally; fetch_err stays 1 until rst.
- stat_en=1 with stat_in=4'b0101 during WAIT -> stat=4'b0101 the next cycle. pc_rst=1 together with pc_write=1 -> pc=0.
- rst asserted during WAIT, then imem_rdy pulses -> ir stays 0, ir_valid stays 0, state=IDLE, pc=0.
